psram_rx_buf: RTL and testbench
===============================

PSRAM_RX_BUF -- requirements
Module: psram_rx_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of 32-bit FIFO entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port hclk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port hrstn, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, a synchronous transfer-init pulse.
REQ-005 The block SHALL have port rx_vld, input, 1, a one-cycle strobe meaning rx_data holds a received PSRAM word.
REQ-006 The block SHALL have port rx_data, input, 32, the received word, sampled only when rx_vld=1.
REQ-007 The block SHALL have port rx_ready, output, 1, meaning the FIFO is not full.
REQ-008 The block SHALL have port ram_wr_req, output, 1, a RAM write request, high while the FIFO is non-empty.
REQ-009 The block SHALL have port ram_wr_ack, input, 1, a RAM write accept, meaningful only while ram_wr_req=1.
REQ-010 The block SHALL have port ram_wdata, output, 32, the head FIFO entry, valid while ram_wr_req=1.
REQ-011 The block SHALL have port rx_ovf, output, 1, a sticky overflow flag.
REQ-012 The block SHALL have port wr_words, output, 16, the count of words written to RAM since the last start or reset.

Function
REQ-013 The block SHALL hold the FIFO as a DEPTH x 32 register array with read and write pointers (log2(DEPTH) bits, natural wrap) and an occupancy count (log2(DEPTH)+1 bits).
REQ-014 The block SHALL define push = rx_vld & (~full | pop) and pop = ram_wr_req & ram_wr_ack, where full = (count==DEPTH) and empty = (count==0).
REQ-015 On push, the block SHALL write rx_data at the write pointer and advance the write pointer by 1.
REQ-016 On pop, the block SHALL advance the read pointer by 1.
REQ-017 The block SHALL update count as +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-018 The block SHALL drive ram_wr_req = ~empty and ram_wdata = entry[read pointer] combinationally, so that data written by a push appears at the output one cycle later.
REQ-019 The block SHALL hold ram_wdata stable while ram_wr_req=1 and ram_wr_ack=0.
REQ-020 The block SHALL drive rx_ready = ~full; rx_ready SHALL NOT depend combinationally on ram_wr_ack.
REQ-021 When full, a simultaneous rx_vld and pop SHALL accept the word, and count SHALL stay at DEPTH.
REQ-022 When rx_vld=1, full=1 and pop=0, the block SHALL drop the word, leave the FIFO unchanged, and set rx_ovf on the next edge.
REQ-023 rx_ovf SHALL stay set until start or reset.
REQ-024 When empty, rx_vld SHALL be accepted; the word SHALL NOT bypass to ram_wdata in the same cycle.
REQ-025 A ram_wr_ack while ram_wr_req=0 SHALL be ignored.
REQ-026 wr_words SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-027 start=1 SHALL, on that edge, clear the pointers, count, rx_ovf and wr_words, overriding any simultaneous push or pop; the data in that cycle is discarded.
REQ-028 The block SHALL contain no clock-domain crossing; rx_vld/rx_data arrive already in the hclk domain.

Reset
REQ-029 While hrstn=0, the block SHALL immediately force pointers=0, count=0, rx_ovf=0, wr_words=0, giving ram_wr_req=0, rx_ready=1.
REQ-030 The FIFO data array SHALL have no reset; ram_wdata is don't-care while ram_wr_req=0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered data, with no RAM write after release until a new push.

Verification
REQ-032 Reset then push 0x11111111, 0x22222222 with ram_wr_ack=1 held -> ram_wr_req rises 1 cycle after the first push, ram_wdata shows 0x11111111 then 0x22222222, wr_words=2, rx_ovf=0.
REQ-033 DEPTH=4, ram_wr_ack=0, five back-to-back pushes of 0xA0..0xA4 -> rx_ready=0 after the 4th, the 5th is dropped, rx_ovf=1; then ack each cycle -> output is 0xA0..0xA3 only, wr_words=4.
REQ-034 FIFO full, rx_vld=1 and ram_wr_ack=1 in the same cycle with 0xB5 -> no overflow, count stays 4, 0xB5 is delivered last.
REQ-035 With 3 entries queued, pulse start together with rx_vld -> next cycle count=0, ram_wr_req=0, rx_ovf=0, wr_words=0, and the pushed word is lost.
REQ-036 Preload wr_words by 65535 pops, then one more pop -> wr_words=0x0000.
REQ-037 Assert hrstn=0 asynchronously mid-stream between clock edges -> ram_wr_req drops without waiting for a clock edge and rx_ready=1.

Source files
------------

// File: rtl/psram_rx_buf.sv
// PSRAM receive buffer: small FIFO between the PSRAM read datapath and the
// RAM write port. Counts delivered words and flags dropped words.
module psram_rx_buf #(
    parameter int DEPTH = 4
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        start,
    input  logic        rx_vld,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        ram_wr_req,
    input  logic        ram_wr_ack,
    output logic [31:0] ram_wdata,
    output logic        rx_ovf,
    output logic [15:0] wr_words
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign pop   = ram_wr_req & ram_wr_ack;
    assign push  = rx_vld & (~full | pop);

    // Head entry is read straight from the array; a word pushed into an
    // empty FIFO appears here only after the write edge.
    assign ram_wr_req = ~empty;
    assign ram_wdata  = mem[rd_ptr];
    // Registered-state only, so no combinational path from ram_wr_ack.
    assign rx_ready   = ~full;

    // Data array write; no reset on the storage itself.
    always_ff @(posedge hclk) begin
        if (push && !start) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers, occupancy, overflow flag and delivered-word counter.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ovf   <= 1'b0;
            wr_words <= '0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ovf   <= 1'b0;
            wr_words <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                wr_words <= wr_words + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (rx_vld && full && !pop) begin
                rx_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psram_rx_buf.sv
// Bench for psram_rx_buf: directed vector table, hand sequences for reset,
// bypass and counter wrap, then random traffic against a queue model.
module tb_psram_rx_buf;
    localparam int DEPTH = 4;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        start = 1'b0;
    logic        rx_vld = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_ready;
    logic        ram_wr_req;
    logic        ram_wr_ack = 1'b0;
    logic [31:0] ram_wdata;
    logic        rx_ovf;
    logic [15:0] wr_words;

    int checks = 0;
    int failures = 0;

    psram_rx_buf #(.DEPTH(DEPTH)) dut (
        .hclk(hclk), .hrstn(hrstn), .start(start), .rx_vld(rx_vld),
        .rx_data(rx_data), .rx_ready(rx_ready), .ram_wr_req(ram_wr_req),
        .ram_wr_ack(ram_wr_ack), .ram_wdata(ram_wdata), .rx_ovf(rx_ovf),
        .wr_words(wr_words)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        st;
        logic        vld;
        logic [31:0] d;
        logic        ack;
        logic        req;
        logic        rdy;
        logic [31:0] wd;
        logic        ovf;
        logic [15:0] w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic vld, logic [31:0] d, logic ack,
                                logic req, logic rdy, logic [31:0] wd,
                                logic ovf, logic [15:0] w);
        vec_t v;
        v.st = st; v.vld = vld; v.d = d; v.ack = ack;
        v.req = req; v.rdy = rdy; v.wd = wd; v.ovf = ovf; v.w = w;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, return 1ns after the rising edge.
    task automatic cyc(logic st, logic vld, logic [31:0] d, logic ack);
        @(negedge hclk);
        start = st; rx_vld = vld; rx_data = d; ram_wr_ack = ack;
        @(posedge hclk);
        #1;
    endtask

    // Behavioural reference for random traffic.
    logic [31:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_words;

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_req", ram_wr_req, 0);
        chk("rst_rdy", rx_ready, 1);
        chk("rst_ovf", rx_ovf, 0);
        chk("rst_words", wr_words, 0);
        @(negedge hclk);
        hrstn = 1'b1;

        // ---------------- basic two-word transfer, ack held ----------------
        @(negedge hclk);
        rx_vld = 1; rx_data = 32'h11111111; ram_wr_ack = 1;
        #1;
        chk("nobypass_req", ram_wr_req, 0);
        @(posedge hclk); #1;
        chk("b1_req", ram_wr_req, 1);
        chk("b1_wd", ram_wdata, 32'h11111111);
        cyc(0, 1, 32'h22222222, 1);
        chk("b2_wd", ram_wdata, 32'h22222222);
        chk("b2_words", wr_words, 1);
        cyc(0, 0, 0, 1);
        chk("b3_req", ram_wr_req, 0);
        chk("b3_words", wr_words, 2);
        chk("b3_ovf", rx_ovf, 0);
        cyc(1, 0, 0, 0);

        // ---------------- table: overflow, full+pop, start ----------------
        tbl.push_back(mk(0,1,32'hA0,0, 1,1,32'hA0,0,0));
        tbl.push_back(mk(0,1,32'hA1,0, 1,1,32'hA0,0,0));
        tbl.push_back(mk(0,1,32'hA2,0, 1,1,32'hA0,0,0));
        tbl.push_back(mk(0,1,32'hA3,0, 1,0,32'hA0,0,0));
        tbl.push_back(mk(0,1,32'hA4,0, 1,0,32'hA0,1,0));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hA1,1,1));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hA2,1,2));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hA3,1,3));
        tbl.push_back(mk(0,0,0,1,      0,1,32'h0,1,4));
        tbl.push_back(mk(0,0,0,1,      0,1,32'h0,1,4));
        tbl.push_back(mk(1,0,0,0,      0,1,32'h0,0,0));
        tbl.push_back(mk(0,1,32'hB1,0, 1,1,32'hB1,0,0));
        tbl.push_back(mk(0,1,32'hB2,0, 1,1,32'hB1,0,0));
        tbl.push_back(mk(0,1,32'hB3,0, 1,1,32'hB1,0,0));
        tbl.push_back(mk(0,1,32'hB4,0, 1,0,32'hB1,0,0));
        tbl.push_back(mk(0,1,32'hB5,1, 1,0,32'hB2,0,1));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hB3,0,2));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hB4,0,3));
        tbl.push_back(mk(0,0,0,1,      1,1,32'hB5,0,4));
        tbl.push_back(mk(0,0,0,1,      0,1,32'h0,0,5));
        tbl.push_back(mk(0,1,32'hC1,0, 1,1,32'hC1,0,5));
        tbl.push_back(mk(0,1,32'hC2,0, 1,1,32'hC1,0,5));
        tbl.push_back(mk(0,1,32'hC3,0, 1,1,32'hC1,0,5));
        tbl.push_back(mk(1,1,32'hC4,0, 0,1,32'h0,0,0));
        tbl.push_back(mk(0,0,0,1,      0,1,32'h0,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].st, tbl[i].vld, tbl[i].d, tbl[i].ack);
            chk($sformatf("row%0d_req", i), ram_wr_req, tbl[i].req);
            chk($sformatf("row%0d_rdy", i), rx_ready, tbl[i].rdy);
            chk($sformatf("row%0d_ovf", i), rx_ovf, tbl[i].ovf);
            chk($sformatf("row%0d_words", i), wr_words, tbl[i].w);
            if (tbl[i].req) chk($sformatf("row%0d_wd", i), ram_wdata, tbl[i].wd);
        end

        // ---------------- async reset mid-stream ----------------
        cyc(0, 1, 32'hD1, 0);
        cyc(0, 1, 32'hD2, 0);
        @(negedge hclk);
        rx_vld = 0; ram_wr_ack = 0;
        #2 hrstn = 1'b0;
        #1;
        chk("arst_req", ram_wr_req, 0);
        chk("arst_rdy", rx_ready, 1);
        @(negedge hclk);
        hrstn = 1'b1;
        cyc(0, 0, 0, 1);
        chk("arst_after_req", ram_wr_req, 0);
        chk("arst_after_words", wr_words, 0);

        // ---------------- wr_words wrap ----------------
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 65536; i++) cyc(0, 1, i, 1);
        chk("wrap_ffff", wr_words, 16'hFFFF);
        cyc(0, 0, 0, 1);
        chk("wrap_zero", wr_words, 16'h0000);
        chk("wrap_req", ram_wr_req, 0);

        // ---------------- random traffic vs queue model ----------------
        cyc(1, 0, 0, 0);
        mq.delete(); m_ovf = 0; m_words = 0;
        for (int n = 0; n < 2000; n++) begin
            logic st, vld, ack, full, pop, push;
            logic [31:0] d;
            @(negedge hclk);
            st  = ($urandom_range(0, 99) < 2);
            vld = ($urandom_range(0, 99) < 60);
            ack = ($urandom_range(0, 99) < 40);
            d   = $urandom;
            start = st; rx_vld = vld; rx_data = d; ram_wr_ack = ack;
            #1;
            chk("rnd_req", ram_wr_req, mq.size() != 0);
            chk("rnd_rdy", rx_ready, mq.size() != DEPTH);
            chk("rnd_ovf", rx_ovf, m_ovf);
            chk("rnd_words", wr_words, m_words);
            if (mq.size() != 0) chk("rnd_wd", ram_wdata, mq[0]);
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && ack;
            push = vld && (!full || pop);
            if (st) begin
                mq.delete(); m_ovf = 0; m_words = 0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_words = m_words + 16'd1;
                end
                if (vld && full && !pop) m_ovf = 1;
                if (push) mq.push_back(d);
            end
            @(posedge hclk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
